// File: rtl/mdu_pkg.sv
// Shared encodings, default latencies and FSM state type for the multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_HI    = 3'd4;
  localparam logic [2:0] MDU_LO    = 3'd5;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply and divide datapath producing HI/LO results.
module mdu_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               sgn_div;
  logic        [31:0] mag_a;
  logic        [31:0] mag_b;
  logic        [31:0] divisor;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic        [31:0] q;
  logic        [31:0] r;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes so that 0x80000000 / -1 needs no special case.
  always_comb begin
    sgn_div = (op == 2'd2);
    div0    = (b == '0);
    mag_a   = (sgn_div && a[31]) ? 32'(-a) : a;
    mag_b   = (sgn_div && b[31]) ? 32'(-b) : b;
    divisor = div0 ? 32'd1 : mag_b;
    uq      = mag_a / divisor;
    ur      = mag_a % divisor;
    q       = (sgn_div && (a[31] ^ b[31])) ? 32'(-uq) : uq;
    r       = (sgn_div && a[31]) ? 32'(-ur) : ur;
    if (op[1]) begin
      hi = r;
      lo = q;
    end else if (op[0]) begin
      hi = prod_u[63:32];
      lo = prod_u[31:0];
    end else begin
      hi = prod_s[63:32];
      lo = prod_s[31:0];
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: HI/LO registers, fixed-latency busy window, CP0 squash.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] c
);

  mdu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;
  logic [31:0]       pend_hi_q;
  logic [31:0]       pend_lo_q;
  logic              pend_skip_q;

  logic [31:0]       ar_hi;
  logic [31:0]       ar_lo;
  logic              ar_div0;

  mdu_arith u_arith (
    .a    (a),
    .b    (b),
    .op   (sel[1:0]),
    .hi   (ar_hi),
    .lo   (ar_lo),
    .div0 (ar_div0)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_skip_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !req && !sel[2]) begin
            pend_hi_q   <= ar_hi;
            pend_lo_q   <= ar_lo;
            pend_skip_q <= sel[1] && ar_div0;
            cnt_q       <= sel[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_q     <= RUN;
          end else if (we && !req && !start) begin
            if (sel == MDU_HI) hi_q <= a;
            else if (sel == MDU_LO) lo_q <= a;
          end
        end
        RUN: begin
          // Divide by zero still occupies the full window but never commits.
          if (cnt_q == CNT_W'(1)) begin
            if (!pend_skip_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);

  always_comb begin
    c = '0;
    if (sel == MDU_HI) c = hi_q;
    else if (sel == MDU_LO) c = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed scoreboard bench for mdu_ctrl: expected HI/LO and busy length queued at start, checked at completion.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  sel = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] c;

  mdu_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .start (start),
    .we    (we),
    .sel   (sel),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .c     (c)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_hilo(input string tag);
    sel = MDU_HI;
    #1 chk({tag, ".hi"}, c, hi_m);
    sel = MDU_LO;
    #1 chk({tag, ".lo"}, c, lo_m);
  endtask

  function automatic exp_t model(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] hi0, input logic [31:0] lo0);
    exp_t e;
    int sx;
    int sy;
    longint p;
    longint q;
    longint r;
    logic [63:0] pu;
    sx = x;
    sy = y;
    e.hi = hi0;
    e.lo = lo0;
    e.n  = (s == MDU_DIV || s == MDU_DIVU) ? 10 : 5;
    case (s)
      MDU_MULT: begin
        p = longint'(sx) * longint'(sy);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      MDU_MULTU: begin
        pu = {32'd0, x} * {32'd0, y};
        e.hi = pu[63:32];
        e.lo = pu[31:0];
      end
      MDU_DIV: if (y != 0) begin
        q = longint'(sx) / longint'(sy);
        r = longint'(sx) % longint'(sy);
        e.hi = r[31:0];
        e.lo = q[31:0];
      end
      MDU_DIVU: if (y != 0) begin
        e.hi = x % y;
        e.lo = x / y;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Drives a start (optionally with we) for one edge and queues the expected outcome.
  task automatic launch(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y, input logic w);
    exp_t e;
    e = model(s, x, y, hi_m, lo_m);
    sb.push_back(e);
    start = 1'b1;
    we    = w;
    sel   = s;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    we    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit pulse_req);
    exp_t e;
    int n;
    n = 0;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s.sb: observed empty scoreboard expected entry", tag);
      return;
    end
    e = sb.pop_front();
    while (busy === 1'b1 && n < 40) begin
      req = (pulse_req && n == 2);
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    chk({tag, ".cycles"}, 32'(n), 32'(e.n));
    hi_m = e.hi;
    lo_m = e.lo;
    chk_hilo(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk_hilo("reset");
    sel = MDU_MULT;
    #1 chk("reset.c_sel0", c, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    launch(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_done("mult", 1'b0);
    launch(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_done("multu", 1'b0);

    launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("div", 1'b0);
    launch(MDU_DIVU, 32'd7, 32'd0, 1'b0);
    wait_done("divu0", 1'b0);

    start = 1'b1; req = 1'b1; sel = MDU_MULT; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    chk("req_start.busy", 32'(busy), 32'd0);
    we = 1'b1; sel = MDU_HI; a = 32'hCAFE_F00D;
    @(negedge clk);
    we = 1'b0; req = 1'b0;
    chk("req_we.busy", 32'(busy), 32'd0);
    chk_hilo("req_block");
    launch(MDU_MULT, 32'd7, 32'd9, 1'b0);
    wait_done("req_mid", 1'b1);

    we = 1'b1; sel = MDU_HI; a = 32'h1234_5678;
    @(negedge clk);
    we = 1'b0;
    hi_m = 32'h1234_5678;
    chk_hilo("mthi");
    we = 1'b1; sel = MDU_LO; a = 32'h0BAD_BEEF;
    @(negedge clk);
    we = 1'b0;
    lo_m = 32'h0BAD_BEEF;
    chk_hilo("mtlo");
    we = 1'b1; sel = 3'd6; a = 32'hDEAD_BEEF;
    @(negedge clk);
    we = 1'b0;
    #1 chk("sel6.c", c, 32'd0);
    chk_hilo("sel6_we");
    start = 1'b1; sel = 3'd7; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("sel7.busy", 32'(busy), 32'd0);
    launch(MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_done("start_we", 1'b0);

    launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("div_ovf", 1'b0);
    launch(MDU_MULT, 32'd3, 32'hFFFF_FFFC, 1'b0);
    wait_done("b2b_mult", 1'b0);

    launch(MDU_DIV, 32'd100, 32'd7, 1'b0);
    repeat (7) @(negedge clk);
    chk("rst_mid.busy_before", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1 chk("rst_mid.busy", 32'(busy), 32'd0);
    void'(sb.pop_front());
    hi_m = '0;
    lo_m = '0;
    chk_hilo("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    launch(MDU_MULTU, 32'd6, 32'd7, 1'b0);
    wait_done("post_rst", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the Execute stage.
- Accepts mult/multu/div/divu start commands and holds the HI/LO architectural registers.
- Models fixed MIPS latencies with a busy window that the hazard unit uses to stall mfhi/mflo/mthi/mtlo/start.
- Honours the CP0 interrupt/exception request so a flushed E-stage instruction never alters HI/LO.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
req  in  1  CP0 interrupt/exception request; squashes this cycle's start/we
start  in  1  launch operation selected by sel (sel 0..3)
we  in  1  move-to write (mthi sel=4, mtlo sel=5)
sel  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 HI, 5 LO, 6-7 reserved
a  in  32  operand rs (dividend / multiplicand / mt data)
b  in  32  operand rt (divisor / multiplier)
busy  out  1  operation in flight
c  out  32  HI when sel=4, LO when sel=5, else 0 (combinational)

Behaviour:
- Reset (rst=0, async): state IDLE, cnt=0, HI=LO=0, pending regs=0, busy=0.
- FSM states:
  - IDLE: on start&&!req with sel<=3, capture operands and compute results into pend_hi/pend_lo; cnt<=MULT_CYCLES (sel 0,1) or DIV_CYCLES (sel 2,3); go to RUN.
  - RUN: cnt decrements each cycle; when cnt==1, HI<=pend_hi, LO<=pend_lo, return to IDLE.
- busy = (state==RUN). Start sampled at edge t gives busy=1 for exactly N cycles after t; new HI/LO visible on the cycle busy falls.
- Back-to-back starts: a start in the cycle busy falls is accepted (IDLE).
- Start while RUN: ignored; the hazard unit guarantees this cannot happen, and a bench assertion flags it.
- we&&!req in IDLE: sel=4 writes HI<=a, sel=5 writes LO<=a at the same edge (0 latency); busy is unaffected.
  - we in RUN is ignored and flagged by assertion.
  - start and we together: start wins, we is dropped.
- req=1 blocks start and we in that cycle. An op already in RUN is not cancelled; it belongs to an older, committed instruction.
- sel 6/7 with start or we: no effect.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
- Boundaries:
  - Divide by zero: the full busy window runs, HI/LO unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- c is combinational from HI/LO. During RUN it shows the old values; the hazard unit stalls readers.
- Reset asserted mid-RUN: immediate return to IDLE with HI=LO=0.

Decomposition:
- Shared package mdu_pkg:
  - sel encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_HI, MDU_LO.
  - default cycle constants.
  - state enum {IDLE, RUN}.
- One combinational sub-module mdu_arith: a, b, op[1:0] in; hi, lo, div0 out. Keeps sign handling and the divide corner cases isolated.
- The FSM, counter and HI/LO registers live in mdu_ctrl.

Test Plan:
1. mult a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with same operands -> HI=0x00000002, LO=0xFFFFFFFA.
2. div a=-7, b=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu a=7, b=0 -> busy 10 cycles, HI/LO unchanged.
3. start with req=1 in the same cycle -> busy stays 0, HI/LO unchanged; req pulse mid-RUN -> operation completes normally.
4. mthi a=0x12345678 then mflo/mfhi -> c=0x12345678 on sel=4 the next cycle; start+we together -> only the start takes effect.
5. div 0x80000000/0xFFFFFFFF then mult started in the cycle busy falls -> LO=0x80000000, HI=0, then 5-cycle busy for the mult.
6. rst low mid-RUN (cnt=3) -> busy=0 and HI=LO=0 immediately; after release, the next start behaves normally.
